// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
// Shared constants for the ID->EX issue stage and the ALU it feeds.
//   - ALU choice codes (the ALU decodes exactly these values)
//   - IDU op-class codes carried on in_op_type
//   - Operand source selects produced by the decoder
//   - Default datapath / register-index widths
// No ports; import with "import alu_issue_pkg::*;".
// ---------------------------------------------------------------------------
package alu_issue_pkg;

    localparam int BW_DEFAULT = 32;
    localparam int RW_DEFAULT = 5;

    // ALU choice codes shared with the EX-stage ALU.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_NEG  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_NE   = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;

    // Op classes delivered by the IDU; 9..15 are undecodable.
    localparam logic [3:0] OPT_OP     = 4'd0;
    localparam logic [3:0] OPT_OP_IMM = 4'd1;
    localparam logic [3:0] OPT_LUI    = 4'd2;
    localparam logic [3:0] OPT_AUIPC  = 4'd3;
    localparam logic [3:0] OPT_JAL    = 4'd4;
    localparam logic [3:0] OPT_JALR   = 4'd5;
    localparam logic [3:0] OPT_BRANCH = 4'd6;
    localparam logic [3:0] OPT_LOAD   = 4'd7;
    localparam logic [3:0] OPT_STORE  = 4'd8;

    // Operand source selects.
    typedef enum logic [1:0] {
        D1_RS1  = 2'd0,
        D1_PC   = 2'd1,
        D1_ZERO = 2'd2
    } d1_sel_e;

    typedef enum logic [1:0] {
        D2_RS2  = 2'd0,
        D2_IMM  = 2'd1,
        D2_FOUR = 2'd2
    } d2_sel_e;

    // Register-register and register-immediate ALU ops share one funct3 table.
    // Only the register form may turn 000 into a subtract; the immediate form
    // reuses instr[30] as an immediate bit there, so it must stay an add.
    function automatic logic [3:0] arith_choice(input logic [2:0] funct3,
                                                input logic       funct7_5,
                                                input logic       allow_sub);
        logic [3:0] c;
        case (funct3)
            3'b000:  c = (allow_sub && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// ---------------------------------------------------------------------------
// alu_issue_decode
// Purely combinational translation of op class + funct bits into the ALU
// choice code, operand source selects and control flags.
// Ports:
//   op_type   in  4   op class (see alu_issue_pkg OPT_*)
//   funct3    in  3   instr[14:12]
//   funct7_5  in  1   instr[30]
//   choice    out 4   ALU choice code
//   d1_sel    out     d1 source (rs1 / pc / zero)
//   d2_sel    out     d2 source (rs2 / imm / constant 4)
//   wen       out 1   op class writes rd (caller still masks rd==0)
//   br        out 1   conditional branch
//   br_inv    out 1   invert ALU res[0] to get "taken"
//   illegal   out 1   undecodable op class / branch funct3
// ---------------------------------------------------------------------------
import alu_issue_pkg::*;

module alu_issue_decode (
    input  logic [3:0] op_type,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] choice,
    output d1_sel_e    d1_sel,
    output d2_sel_e    d2_sel,
    output logic       wen,
    output logic       br,
    output logic       br_inv,
    output logic       illegal
);

    // Decode table. Defaults describe an illegal-safe bundle (add, no write,
    // no branch) so every unlisted case falls back to harmless values.
    // Branches reduce to three compares: BEQ/BNE use "ne", BLT/BGE use "slt",
    // BLTU/BGEU use "sltu", with br_inv flipping the sense where needed.
    always_comb begin
        choice  = ALU_ADD;
        d1_sel  = D1_RS1;
        d2_sel  = D2_RS2;
        wen     = 1'b0;
        br      = 1'b0;
        br_inv  = 1'b0;
        illegal = 1'b0;
        case (op_type)
            OPT_OP: begin
                choice = arith_choice(funct3, funct7_5, 1'b1);
                wen    = 1'b1;
            end
            OPT_OP_IMM: begin
                choice = arith_choice(funct3, funct7_5, 1'b0);
                d2_sel = D2_IMM;
                wen    = 1'b1;
            end
            OPT_LUI: begin
                d1_sel = D1_ZERO;
                d2_sel = D2_IMM;
                wen    = 1'b1;
            end
            OPT_AUIPC: begin
                d1_sel = D1_PC;
                d2_sel = D2_IMM;
                wen    = 1'b1;
            end
            OPT_JAL, OPT_JALR: begin
                d1_sel = D1_PC;
                d2_sel = D2_FOUR;
                wen    = 1'b1;
            end
            OPT_LOAD: begin
                d2_sel = D2_IMM;
                wen    = 1'b1;
            end
            OPT_STORE: begin
                d2_sel = D2_IMM;
            end
            OPT_BRANCH: begin
                br = 1'b1;
                case (funct3)
                    3'b000: begin choice = ALU_NE;   br_inv = 1'b1; end
                    3'b001: begin choice = ALU_NE;   br_inv = 1'b0; end
                    3'b100: begin choice = ALU_SLT;  br_inv = 1'b0; end
                    3'b101: begin choice = ALU_SLT;  br_inv = 1'b1; end
                    3'b110: begin choice = ALU_SLTU; br_inv = 1'b0; end
                    3'b111: begin choice = ALU_SLTU; br_inv = 1'b1; end
                    default: begin
                        br      = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID->EX issue register. Accepts a decoded bundle from the IDU on a
// valid/ready handshake, decodes the ALU choice, selects d1/d2 and presents
// a registered, stable operand/choice bundle to the ALU.
// Optional build macro: ALU_ISSUE_FWD_EN
//   defined   -> writeback data is forwarded onto rs1/rs2 at capture time
//   undefined -> wb_* ports are ignored
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           IDU handshake (in_ready = !out_valid | out_ready)
//   in_op_type, in_funct3, in_funct7_5   decode fields
//   in_pc, in_rs1_data, in_rs2_data, in_imm   operand candidates
//   in_rs1, in_rs2, in_rd         register indices
//   flush                         drop in-flight and incoming bundle
//   out_valid / out_ready         EX handshake
//   alu_d1, alu_d2, alu_choice    ALU operands and op
//   out_rd, out_wen               destination and write enable
//   out_br, out_br_inv            branch flag and taken-sense inversion
//   out_store_data                rs2 value for stores
//   out_illegal                   undecodable bundle
//   wb_valid, wb_rd, wb_data      writeback bus (forwarding source)
// ---------------------------------------------------------------------------
import alu_issue_pkg::*;

module alu_issue_stage #(
    parameter int BW = BW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op_type,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7_5,
    input  logic [BW-1:0] in_pc,
    input  logic [BW-1:0] in_rs1_data,
    input  logic [BW-1:0] in_rs2_data,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic [BW-1:0] in_imm,
    input  logic [RW-1:0] in_rd,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] alu_d1,
    output logic [BW-1:0] alu_d2,
    output logic [3:0]    alu_choice,
    output logic [RW-1:0] out_rd,
    output logic          out_wen,
    output logic          out_br,
    output logic          out_br_inv,
    output logic [BW-1:0] out_store_data,
    output logic          out_illegal,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_rd,
    input  logic [BW-1:0] wb_data
);

    logic [3:0] dec_choice;
    d1_sel_e    dec_d1_sel;
    d2_sel_e    dec_d2_sel;
    logic       dec_wen;
    logic       dec_br;
    logic       dec_br_inv;
    logic       dec_illegal;

    logic [BW-1:0] rs1_val;
    logic [BW-1:0] rs2_val;
    logic [BW-1:0] op_d1;
    logic [BW-1:0] op_d2;
    logic          xfer;

    logic          out_valid_q,   out_valid_d;
    logic [BW-1:0] alu_d1_q,      alu_d1_d;
    logic [BW-1:0] alu_d2_q,      alu_d2_d;
    logic [3:0]    alu_choice_q,  alu_choice_d;
    logic [RW-1:0] out_rd_q,      out_rd_d;
    logic          out_wen_q,     out_wen_d;
    logic          out_br_q,      out_br_d;
    logic          out_br_inv_q,  out_br_inv_d;
    logic [BW-1:0] store_data_q,  store_data_d;
    logic          out_illegal_q, out_illegal_d;

    alu_issue_decode u_decode (
        .op_type  (in_op_type),
        .funct3   (in_funct3),
        .funct7_5 (in_funct7_5),
        .choice   (dec_choice),
        .d1_sel   (dec_d1_sel),
        .d2_sel   (dec_d2_sel),
        .wen      (dec_wen),
        .br       (dec_br),
        .br_inv   (dec_br_inv),
        .illegal  (dec_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    // Writeback bypass: x0 is never forwarded since it always reads zero.
    always_comb begin
        rs1_val = in_rs1_data;
        rs2_val = in_rs2_data;
        if (wb_valid && (wb_rd != '0) && (wb_rd == in_rs1)) begin
            rs1_val = wb_data;
        end
        if (wb_valid && (wb_rd != '0) && (wb_rd == in_rs2)) begin
            rs2_val = wb_data;
        end
    end
`else
    // Without the bypass the register file values go straight through; the
    // writeback bus and source indices are kept on the port list only so the
    // interface is identical in both builds.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{wb_valid, wb_rd, wb_data, in_rs1, in_rs2};

    always_comb begin
        rs1_val = in_rs1_data;
        rs2_val = in_rs2_data;
    end
`endif

    // Operand source muxes driven by the decoder selects.
    always_comb begin
        case (dec_d1_sel)
            D1_PC:   op_d1 = in_pc;
            D1_ZERO: op_d1 = '0;
            default: op_d1 = rs1_val;
        endcase
        case (dec_d2_sel)
            D2_IMM:  op_d2 = in_imm;
            D2_FOUR: op_d2 = BW'(4);
            default: op_d2 = rs2_val;
        endcase
    end

    // One-deep pipeline register: a slot frees up whenever it is empty or
    // being drained this cycle, which gives full throughput.
    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    // Next-state for the issue register. Everything holds by default so a
    // stalled bundle stays bit-exact. Flush only clears valid and swallows any
    // transfer in the same cycle; the data fields keep their previous values.
    always_comb begin
        out_valid_d   = out_valid_q;
        alu_d1_d      = alu_d1_q;
        alu_d2_d      = alu_d2_q;
        alu_choice_d  = alu_choice_q;
        out_rd_d      = out_rd_q;
        out_wen_d     = out_wen_q;
        out_br_d      = out_br_q;
        out_br_inv_d  = out_br_inv_q;
        store_data_d  = store_data_q;
        out_illegal_d = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_valid_d   = 1'b1;
            alu_d1_d      = op_d1;
            alu_d2_d      = op_d2;
            alu_choice_d  = dec_choice;
            out_rd_d      = in_rd;
            out_wen_d     = dec_wen && (in_rd != '0);
            out_br_d      = dec_br;
            out_br_inv_d  = dec_br_inv;
            store_data_d  = rs2_val;
            out_illegal_d = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            alu_d1_q      <= '0;
            alu_d2_q      <= '0;
            alu_choice_q  <= ALU_ADD;
            out_rd_q      <= '0;
            out_wen_q     <= 1'b0;
            out_br_q      <= 1'b0;
            out_br_inv_q  <= 1'b0;
            store_data_q  <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            alu_d1_q      <= alu_d1_d;
            alu_d2_q      <= alu_d2_d;
            alu_choice_q  <= alu_choice_d;
            out_rd_q      <= out_rd_d;
            out_wen_q     <= out_wen_d;
            out_br_q      <= out_br_d;
            out_br_inv_q  <= out_br_inv_d;
            store_data_q  <= store_data_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_d1         = alu_d1_q;
    assign alu_d2         = alu_d2_q;
    assign alu_choice     = alu_choice_q;
    assign out_rd         = out_rd_q;
    assign out_wen        = out_wen_q;
    assign out_br         = out_br_q;
    assign out_br_inv     = out_br_inv_q;
    assign out_store_data = store_data_q;
    assign out_illegal    = out_illegal_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID→EX issue register for the single-issue RV32I core. It accepts decoded instruction fields from the IDU over a valid/ready handshake and translates op class and funct bits into an ALU choice code. It selects the d1/d2 operand sources and registers everything, presenting a stable, registered operand/choice bundle to the ALU in EX. It is the producer side of the ALU's d1/d2/choice interface.

Parameters:
BW, 32, datapath width (pc, rs1/rs2 data, imm, ALU operands)
RW, 5, register index width

Ports:
clk  in  1  system clock; one clock domain
rst  in  1  synchronous, active-high reset
in_valid  in  1  IDU bundle valid
in_ready  out  1  stage can accept this cycle
in_op_type  in  4  op class: 0 OP, 1 OP_IMM, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH, 7 LOAD, 8 STORE; 9-15 illegal
in_funct3  in  3  instr[14:12]
in_funct7_5  in  1  instr[30]
in_pc  in  BW  instruction pc
in_rs1_data, in_rs2_data  in  BW  register file read data
in_rs1, in_rs2  in  RW  source indices (used by forwarding)
in_imm  in  BW  sign-extended immediate
in_rd  in  RW  destination index
flush  in  1  kill in-flight and incoming bundle
out_valid  out  1  EX bundle valid
out_ready  in  1  EX consumes bundle
alu_d1, alu_d2  out  BW  ALU operands
alu_choice  out  4  ALU choice code
out_rd  out  RW  destination index
out_wen  out  1  writes rd
out_br  out  1  bundle is a branch
out_br_inv  out  1  branch taken = ALU res[0] XOR out_br_inv
out_store_data  out  BW  rs2 value (forwarded if enabled)
out_illegal  out  1  undecodable bundle
wb_valid  in  1  writeback valid (forwarding only)
wb_rd  in  RW  writeback index
wb_data  in  BW  writeback data

Behaviour:
- Reset (rst high at posedge): out_valid=0; alu_d1, alu_d2, out_store_data=0; alu_choice=0 (add); out_rd=0; out_wen, out_br, out_br_inv, out_illegal=0.
- Choice codes (fixed): add 0, sub 1, neg 2, and 3, or 4, xor 5, slt 6, sltu 7, ne 8 (res=1 when d1≠d2), sll 9, srl 10, sra 11.
- Handshake: in_ready = !out_valid | out_ready (combinational, one-deep register, full throughput). Transfer on in_valid & in_ready. Latency 1 cycle: bundle accepted at edge N is on the outputs after edge N.
- Output hold: while out_valid & !out_ready, every output holds its value exactly.
- When out_ready=1 and no transfer occurs, out_valid→0 and data outputs hold their last values.
- Flush: at the next edge out_valid=0; an input transfer in the same cycle is dropped. in_ready is unaffected by flush. rst has priority over flush.
- Decode, OP: funct3 000 add/sub (funct7_5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra (funct7_5), 110 or, 111 and. d1=rs1, d2=rs2.
- Decode, OP_IMM: same mapping, except 000 is always add. d1=rs1, d2=imm.
- Decode, LUI: d1=0, d2=imm, add. AUIPC: d1=pc, d2=imm, add.
- Decode, JAL/JALR: d1=pc, d2=4, add (link value).
- Decode, LOAD/STORE: d1=rs1, d2=imm, add.
- Decode, BRANCH: d1=rs1, d2=rs2, out_br=1.
  - 000 ne, inv=1; 001 ne, inv=0
  - 100 slt, inv=0; 101 slt, inv=1
  - 110 sltu, inv=0; 111 sltu, inv=1
  - 010/011 illegal
- out_wen = 1 for OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD when rd≠0; otherwise 0.
- Illegal bundle: out_illegal=1, alu_choice=add, out_wen=0, out_br=0. The bundle still passes the handshake.

Optional Feature:
ALU_ISSUE_FWD_EN.
- Defined: on a transfer, if wb_valid & wb_rd≠0 & wb_rd==in_rs1, wb_data replaces in_rs1_data before operand selection; same rule for rs2 (affects d2 and out_store_data).
- Undefined: wb_* ports are present but ignored; register file data is used directly.

Decomposition:
- Shared package/header: ALU choice constants, op_type constants, BW default.
- The ALU consumes the same choice constants from that package.
- One sub-module: alu_issue_decode, purely combinational. Inputs op_type, funct3, funct7_5. Outputs choice, d1/d2 source selects, wen, br, br_inv, illegal.
- Top level holds the handshake register, flush, and forwarding muxes.

Test Plan:
- OP, funct3=000, funct7_5=1, rs1=7, rs2=3, rd=5, out_ready=1 → next cycle out_valid=1, choice=1, d1=7, d2=3, out_wen=1, out_rd=5.
- BRANCH funct3=101 (BGE), rs1=0xFFFFFFFF, rs2=1 → choice=6, out_br=1, out_br_inv=1, out_wen=0.
- Back-pressure: accept AUIPC pc=0x80000000 imm=0x1000, hold out_ready=0 for 3 cycles with new in_valid → in_ready=0, outputs stable (d1=0x80000000, d2=0x1000); out_ready=1 → new bundle follows next cycle.
- Flush in the same cycle as a transfer of JAL pc=0x100 → next cycle out_valid=0; following bundle is accepted normally.
- in_op_type=12, or BRANCH with funct3=010 → out_illegal=1, choice=0, out_wen=0; rst asserted mid-stream → all outputs 0 the next cycle.
- With ALU_ISSUE_FWD_EN: OP rs1=4, in_rs1_data=1, wb_valid=1, wb_rd=4, wb_data=0x55 → d1=0x55. With wb_rd=0 → d1=1.
